// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between the CPU command
// bus and the debug/loader req/ack port. Registered fixed-priority arbiter
// (CPU first) with a streak limit so a pending loader request is never starved.
//
// Handshakes:
//   CPU    - cpu_cmd (01 READ, 10 WRITE; 00/11 idle) is sampled only at the
//            grant edge; cpu_ready pulses for one cycle when the access is done.
//   Loader - dbg_req is held until dbg_ack; dbg_ack pulses for one cycle.
//   A command still present during its own completion (DONE) cycle is treated
//   as a new CPU command, while a still-high dbg_req in its DONE cycle is the
//   request being acknowledged and is not re-served.
//
// Optional build macro: MEM_ARB_STATS_EN adds cpu_grant_cnt / dbg_grant_cnt.
// fsm_state exposes the FSM state (0 IDLE, 1 ACC, 2 DONE).
module mem_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 16,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        cpu_cmd,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        fsm_state
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]       cpu_grant_cnt,
  output logic [15:0]       dbg_grant_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int              SW         = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_STREAK);
  localparam logic            OWN_CPU    = 1'b0;
  localparam logic            OWN_DBG    = 1'b1;

  state_t              state_q, state_d;
  logic                owner_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [SW-1:0]       streak_q;
  logic [DATA_W-1:0]   cpu_hold_q;
  logic [DATA_W-1:0]   dbg_hold_q;
  logic                cpu_cand, dbg_cand;
  logic                grant_cpu, grant_dbg;
  logic                in_done;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Arbitration and next state; arbitration happens only in IDLE and DONE.
  always_comb begin
    cpu_cand  = 1'b0;
    dbg_cand  = 1'b0;
    grant_cpu = 1'b0;
    grant_dbg = 1'b0;
    state_d   = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        cpu_cand  = (cpu_cmd == 2'b01) || (cpu_cmd == 2'b10);
        dbg_cand  = dbg_req && !((state_q == S_DONE) && (owner_q == OWN_DBG));
        grant_dbg = dbg_cand && (!cpu_cand || (streak_q == STREAK_MAX));
        grant_cpu = cpu_cand && !grant_dbg;
        state_d   = (grant_cpu || grant_dbg) ? S_ACC : S_IDLE;
      end
      S_ACC:   state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Latch the winning request and update the CPU streak on each grant edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q  <= OWN_CPU;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      streak_q <= '0;
    end else if (grant_cpu) begin
      owner_q  <= OWN_CPU;
      we_q     <= (cpu_cmd == 2'b10);
      addr_q   <= cpu_addr;
      wdata_q  <= cpu_wdata;
      if (streak_q != STREAK_MAX) streak_q <= streak_q + SW'(1);
    end else if (grant_dbg) begin
      owner_q  <= OWN_DBG;
      we_q     <= dbg_we;
      addr_q   <= dbg_addr;
      wdata_q  <= dbg_wdata;
      streak_q <= '0;
    end
  end

  // Capture read data into the owner's hold register at the end of DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_hold_q <= '0;
      dbg_hold_q <= '0;
    end else if (in_done && !we_q) begin
      if (owner_q == OWN_CPU) cpu_hold_q <= ram_rdata;
      else                    dbg_hold_q <= ram_rdata;
    end
  end

`ifdef MEM_ARB_STATS_EN
  // Per-requester grant counters, wrapping at 16 bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_grant_cnt <= '0;
      dbg_grant_cnt <= '0;
    end else begin
      if (grant_cpu) cpu_grant_cnt <= cpu_grant_cnt + 16'd1;
      if (grant_dbg) dbg_grant_cnt <= dbg_grant_cnt + 16'd1;
    end
  end
`endif

  // RAM side: address/data always show the latched access; write only in ACC.
  assign in_done   = (state_q == S_DONE);
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_we    = (state_q == S_ACC) && we_q;

  // Requester side: completion pulses and read data (live in DONE, then held).
  assign cpu_ready = in_done && (owner_q == OWN_CPU);
  assign dbg_ack   = in_done && (owner_q == OWN_DBG);
  assign cpu_rdata = (cpu_ready && !we_q) ? ram_rdata : cpu_hold_q;
  assign dbg_rdata = (dbg_ack && !we_q) ? ram_rdata : dbg_hold_q;
  assign fsm_state = state_q;

endmodule
